// File: rtl/debug_unit.sv
// Debug unit: UART-driven instruction loader, run/step control and PC + register-file dump.
// Optional single-step command ('S') is built only when DEBUG_UNIT_STEP_EN is defined.
module debug_unit #(
  parameter int INST_SZ = 32,
  parameter int REG_SZ  = 5,
  parameter int BYTE_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_enable,
  output logic [REG_SZ-1:0]  o_debug_addr,
  input  logic [INST_SZ-1:0] i_pc,
  input  logic [INST_SZ-1:0] i_data,
  input  logic               i_halt,
  output logic [2:0]         o_fsm_state
);

  localparam int BYTES    = INST_SZ / BYTE_SZ;
  localparam int BCNT_W   = $clog2(BYTES);
  localparam int WIDX_W   = REG_SZ + 1;
  localparam int NUM_REGS = 2 ** REG_SZ;

  localparam logic [BYTE_SZ-1:0] CMD_LOAD  = BYTE_SZ'(8'h4C);
  localparam logic [BYTE_SZ-1:0] CMD_RUN   = BYTE_SZ'(8'h52);
  localparam logic [BYTE_SZ-1:0] CMD_STEP  = BYTE_SZ'(8'h53);
  localparam logic [INST_SZ-1:0] HALT_WORD = INST_SZ'(32'h0000003F);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RUN        = 3'd2,
    ST_DUMP_LATCH = 3'd3,
    ST_DUMP_SEND  = 3'd4,
    ST_DUMP_WAIT  = 3'd5
`ifdef DEBUG_UNIT_STEP_EN
    ,
    ST_STEP       = 3'd6
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [INST_SZ-1:0]  word_q, word_d;
  logic [BCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                wr_q, wr_d;
  logic [INST_SZ-1:0]  instr_q, instr_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [INST_SZ-1:0]  shreg_q, shreg_d;
  logic                enable;
  logic                tx_start;
  logic [REG_SZ-1:0]   dbg_addr;

  // Handshakes: a byte is taken only in a cycle where i_rx_done is high; after the
  // single-cycle o_tx_start, o_tx_data is held until i_tx_done pulses for that byte.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    lcnt_d   = lcnt_q;
    wr_d     = 1'b0;
    instr_d  = instr_q;
    widx_d   = widx_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    enable   = 1'b0;
    tx_start = 1'b0;
    dbg_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) state_d = ST_LOAD;
          else if (i_rx_data == CMD_RUN) state_d = ST_RUN;
`ifdef DEBUG_UNIT_STEP_EN
          else if (i_rx_data == CMD_STEP) state_d = ST_STEP;
`endif
        end
      end
      ST_LOAD: begin
        if (i_rx_done) begin
          word_d = {word_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};
          if (lcnt_q == BCNT_W'(BYTES - 1)) begin
            lcnt_d  = '0;
            wr_d    = 1'b1;
            instr_d = word_d;
            if (word_d == HALT_WORD) state_d = ST_IDLE;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Enable drops combinationally in the first cycle halt is seen.
        if (i_halt) state_d = ST_DUMP_LATCH;
        else enable = 1'b1;
      end
`ifdef DEBUG_UNIT_STEP_EN
      ST_STEP: begin
        enable  = 1'b1;
        state_d = ST_DUMP_LATCH;
      end
`endif
      ST_DUMP_LATCH: begin
        if (widx_q == '0) begin
          shreg_d = i_pc;
        end else begin
          dbg_addr = REG_SZ'(widx_q - 1'b1);
          shreg_d  = i_data;
        end
        bcnt_d  = '0;
        state_d = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        tx_start = 1'b1;
        state_d  = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (bcnt_q == BCNT_W'(BYTES - 1)) begin
            bcnt_d = '0;
            if (widx_q == WIDX_W'(NUM_REGS)) begin
              widx_d  = '0;
              shreg_d = '0;
              state_d = ST_IDLE;
            end else begin
              widx_d  = widx_q + 1'b1;
              state_d = ST_DUMP_LATCH;
            end
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            shreg_d = shreg_q << BYTE_SZ;
            state_d = ST_DUMP_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      lcnt_q  <= '0;
      wr_q    <= 1'b0;
      instr_q <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lcnt_q  <= lcnt_d;
      wr_q    <= wr_d;
      instr_q <= instr_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Outputs are forced quiet in any cycle reset is asserted, not just after it.
  assign o_write       = wr_q & ~i_reset;
  assign o_instruction = i_reset ? '0 : instr_q;
  assign o_enable      = enable & ~i_reset;
  assign o_tx_start    = tx_start & ~i_reset;
  assign o_tx_data     = i_reset ? '0 : shreg_q[INST_SZ-1 -: BYTE_SZ];
  assign o_debug_addr  = i_reset ? '0 : dbg_addr;
  assign o_fsm_state   = state_q;

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameter INST_SZ, default 32, instruction/data word width in bits.
REQ-002 Parameter REG_SZ, default 5, register-file address width in bits.
REQ-003 Parameter BYTE_SZ, default 8, serial byte width in bits.
REQ-004 i_clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_rx_data  input  BYTE_SZ  byte received from the UART receiver.
REQ-007 i_rx_done  input  1  one-cycle pulse; i_rx_data is valid in that cycle.
REQ-008 i_tx_done  input  1  one-cycle pulse; the UART transmitter has finished the current byte.
REQ-009 o_tx_data  output  BYTE_SZ  byte to transmit.
REQ-010 o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-011 o_write  output  1  pipeline instruction-memory write strobe.
REQ-012 o_instruction  output  INST_SZ  instruction word to be written.
REQ-013 o_enable  output  1  pipeline clock enable.
REQ-014 o_debug_addr  output  REG_SZ  register-file read address.
REQ-015 i_pc  input  INST_SZ  current pipeline PC.
REQ-016 i_data  input  INST_SZ  register value at o_debug_addr (combinational read).
REQ-017 i_halt  input  1  pipeline has retired HALT (0x0000003F).

Function
REQ-018 FSM states: IDLE, LOAD, RUN, STEP, DUMP_LATCH, DUMP_SEND, DUMP_WAIT.
REQ-019 IDLE: an rx byte 0x4C ('L') SHALL go to LOAD, 0x52 ('R') to RUN, 0x53 ('S') to STEP; any other byte SHALL be ignored.
REQ-020 LOAD: rx bytes SHALL be assembled MSB-first into a 32-bit word; the byte counter SHALL wrap 3->0.
REQ-021 On the 4th byte, the next cycle SHALL drive o_instruction with the word and pulse o_write high for exactly one cycle.
REQ-022 If the written word equals 0x0000003F, the FSM SHALL return to IDLE after the write; otherwise it SHALL remain in LOAD.
REQ-023 RUN: o_enable SHALL be held high from the cycle after entry until the first cycle i_halt is sampled high, then deasserted that cycle; next state DUMP_LATCH.
REQ-024 RUN entered while i_halt is already high SHALL produce zero o_enable cycles and go straight to DUMP_LATCH.
REQ-025 STEP: o_enable SHALL be high for exactly one cycle, then next state DUMP_LATCH.
REQ-026 Dump order: PC word, then registers 0..31; 33 words, 132 bytes, each word MSB-first.
REQ-027 DUMP_LATCH: latch i_pc (word 0) or i_data with o_debug_addr = word index - 1 into a shift register.
REQ-028 DUMP_SEND: drive o_tx_data with the top byte and pulse o_tx_start for one cycle; then DUMP_WAIT.
REQ-029 DUMP_WAIT: on i_tx_done, shift the register left 8 and go to DUMP_SEND, or after the 4th byte go to DUMP_LATCH for the next word, or to IDLE after word 32.
REQ-030 rx bytes received outside IDLE/LOAD SHALL be discarded.
REQ-031 o_write and o_enable SHALL never be high in the same cycle.

Reset
REQ-032 i_reset high at any clock edge, including mid-load or mid-dump, SHALL force IDLE and zero all counters.
REQ-033 During and after reset: o_write=0, o_enable=0, o_tx_start=0, o_tx_data=0, o_instruction=0, o_debug_addr=0.

Configuration
REQ-034 With DEBUG_UNIT_STEP_EN defined, 'S' SHALL behave per REQ-025.
REQ-035 Without DEBUG_UNIT_STEP_EN, the STEP state SHALL not exist and 'S' SHALL be ignored like any unknown byte.

Verification
REQ-036 Bytes 'L', 20 02 00 02, 00 00 00 3F -> o_write pulses twice (0x20020002, then 0x0000003F); FSM in IDLE.
REQ-037 'R' with i_halt asserted 5 cycles later -> o_enable high exactly 5 cycles; 132 o_tx_start pulses; first 4 bytes equal i_pc.
REQ-038 Dump with register 2 = 0x00000002 -> bytes 13..16 (1-based) are 00 00 00 02.
REQ-039 'L', 12 34, then i_reset, then 'R' -> no o_write pulse; RUN entered normally.
REQ-040 Byte 0x41 in IDLE -> no output activity; a following 'S' -> one o_enable cycle and a 132-byte dump (macro defined) or nothing (macro undefined).
